// File: rtl/lab2_proc_alu_req_resp.sv
// ALU request/response endpoint: requests {fn, in0, in1} are evaluated by a
// combinational ALU on the accepting edge. Each result, together with its
// comparison flags, is stored in a 2-entry response queue. Responses are
// returned in request order.

module lab2_proc_ProcDpathAlu (
    input  logic [3:0]  i_fn,
    input  logic [31:0] i_in0,
    input  logic [31:0] i_in1,
    output logic [31:0] o_out,
    output logic        o_ops_eq,
    output logic        o_ops_lt,
    output logic        o_ops_ltu,
    output logic        o_err
);
    logic signed [31:0] w_in0_s;
    logic signed [31:0] w_in1_s;
    logic        [4:0]  w_shamt;
    logic        [31:0] w_sum;

    assign w_in0_s = $signed(i_in0);
    assign w_in1_s = $signed(i_in1);
    assign w_shamt = i_in1[4:0];
    assign w_sum   = i_in0 + i_in1;

    // Flags are independent of fn, so they are valid for every operation.
    assign o_ops_eq  = (i_in0 == i_in1);
    assign o_ops_lt  = (w_in0_s < w_in1_s);
    assign o_ops_ltu = (i_in0 < i_in1);

    // Result multiplexer; fn 13..15 are illegal and report err with a zero result.
    always_comb begin
        o_out = 32'd0;
        o_err = 1'b0;
        case (i_fn)
            4'd0:    o_out = w_sum;
            4'd1:    o_out = i_in0 - i_in1;
            4'd2:    o_out = i_in0 & i_in1;
            4'd3:    o_out = i_in0 | i_in1;
            4'd4:    o_out = i_in0 ^ i_in1;
            4'd5:    o_out = {31'd0, o_ops_lt};
            4'd6:    o_out = {31'd0, o_ops_ltu};
            4'd7:    o_out = $unsigned(w_in0_s >>> w_shamt);
            4'd8:    o_out = i_in0 >> w_shamt;
            4'd9:    o_out = i_in0 << w_shamt;
            4'd10:   o_out = w_sum & 32'hFFFF_FFFE;
            4'd11:   o_out = i_in0;
            4'd12:   o_out = i_in1;
            default: o_err = 1'b1;
        endcase
    end
endmodule

module lab2_proc_alu_req_resp #(
    parameter int p_num_entries = 2,
    parameter int p_cnt_nbits   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_val,
    output logic                   req_rdy,
    input  logic [67:0]            req_msg,
    output logic                   resp_val,
    input  logic                   resp_rdy,
    output logic [35:0]            resp_msg,
    output logic [p_cnt_nbits-1:0] num_ops
);
    localparam logic [1:0] LP_FULL = 2'(p_num_entries);

    logic [1:0]             r_count;
    logic                   r_enq_ptr;
    logic                   r_deq_ptr;
    logic [p_cnt_nbits-1:0] r_num_ops;
    logic [35:0]            r_data [2];

    logic [31:0] w_out;
    logic        w_eq;
    logic        w_lt;
    logic        w_ltu;
    logic        w_err;
    logic        w_enq;
    logic        w_deq;

    lab2_proc_ProcDpathAlu u_alu (
        .i_fn      (req_msg[67:64]),
        .i_in0     (req_msg[63:32]),
        .i_in1     (req_msg[31:0]),
        .o_out     (w_out),
        .o_ops_eq  (w_eq),
        .o_ops_lt  (w_lt),
        .o_ops_ltu (w_ltu),
        .o_err     (w_err)
    );

    // Handshake outputs come only from registered occupancy, so there is no
    // combinational path from req_val or resp_rdy to either ready/valid.
    assign req_rdy  = (r_count != LP_FULL);
    assign resp_val = (r_count != 2'd0);
    assign resp_msg = r_data[r_deq_ptr];
    assign num_ops  = r_num_ops;

    assign w_enq = req_val && req_rdy;
    assign w_deq = resp_val && resp_rdy;

    // Queue control and the saturating transfer counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= 2'd0;
            r_enq_ptr <= 1'b0;
            r_deq_ptr <= 1'b0;
            r_num_ops <= '0;
        end else begin
            if (w_enq) r_enq_ptr <= ~r_enq_ptr;
            if (w_deq) r_deq_ptr <= ~r_deq_ptr;
            if (w_enq && !w_deq) r_count <= r_count + 2'd1;
            else if (!w_enq && w_deq) r_count <= r_count - 2'd1;
            if (w_deq && (r_num_ops != '1)) r_num_ops <= r_num_ops + 1'b1;
        end
    end

    // Payload storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (w_enq) r_data[r_enq_ptr] <= {w_err, w_ltu, w_lt, w_eq, w_out};
    end
endmodule

// File: tb/tb_lab2_proc_alu_req_resp.sv
// Bench for lab2_proc_alu_req_resp: directed scenarios plus random traffic
// checked against a queue-based reference model.

module tb_lab2_proc_alu_req_resp;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_val;
    logic        req_rdy;
    logic [67:0] req_msg;
    logic        resp_val;
    logic        resp_rdy;
    logic [35:0] resp_msg;
    logic [15:0] num_ops;

    int n_checks = 0;
    int n_errors = 0;

    logic [35:0] mq[$];
    int          exp_num;
    logic        fire_req;
    logic        fire_resp;
    logic [67:0] cap_msg;

    lab2_proc_alu_req_resp #(.p_num_entries(2), .p_cnt_nbits(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_msg  (req_msg),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (resp_msg),
        .num_ops  (num_ops)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU computed with plain 64-bit arithmetic.
    function automatic logic [35:0] ref_alu(input logic [67:0] m);
        logic [3:0]      fn;
        longint unsigned a, b, p, r;
        longint          sa, sb, q;
        logic            err;
        logic [31:0]     o;
        fn = m[67:64];
        a  = longint'(m[63:32]);
        b  = longint'(m[31:0]);
        sa = longint'($signed(m[63:32]));
        sb = longint'($signed(m[31:0]));
        p  = 1;
        repeat (int'(m[4:0])) p = p * 2;
        err = 1'b0;
        r   = 0;
        case (fn)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = (sa < sb) ? 1 : 0;
            4'd6:  r = (a < b) ? 1 : 0;
            4'd7:  begin
                       if (sa < 0) q = -((-sa - 1) / longint'(p)) - 1;
                       else        q = sa / longint'(p);
                       r = longint'(q);
                   end
            4'd8:  r = a / p;
            4'd9:  r = a * p;
            4'd10: r = (a + b) - ((a + b) % 2);
            4'd11: r = a;
            4'd12: r = b;
            default: begin r = 0; err = 1'b1; end
        endcase
        o = r[31:0];
        return {err, (a < b), (sa < sb), (a == b), o};
    endfunction

    task automatic check_model();
        fire_req  = req_val && (mq.size() != 2);
        fire_resp = resp_rdy && (mq.size() != 0);
        cap_msg   = req_msg;
        chk("req_rdy", {63'd0, req_rdy}, {63'd0, mq.size() != 2});
        chk("resp_val", {63'd0, resp_val}, {63'd0, mq.size() != 0});
        if (mq.size() != 0) chk("resp_msg", {28'd0, resp_msg}, {28'd0, mq[0]});
        chk("num_ops", {48'd0, num_ops}, 64'(exp_num));
    endtask

    task automatic update_model();
        if (fire_resp) begin
            void'(mq.pop_front());
            if (exp_num != 65535) exp_num++;
        end
        if (fire_req) mq.push_back(ref_alu(cap_msg));
    endtask

    task automatic cycle();
        @(negedge clk);
        check_model();
        @(posedge clk); #1;
        update_model();
    endtask

    task automatic send(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
        int k;
        k = 0;
        req_val = 1'b1;
        req_msg = {fn, a, b};
        do begin
            cycle();
            k++;
        end while (!fire_req && k < 50);
        if (!fire_req) chk("send_timeout", 64'd0, 64'd1);
        req_val = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [35:0] e);
        resp_rdy = 1'b1;
        @(negedge clk);
        chk("pop_val", {63'd0, resp_val}, 64'd1);
        chk(tag, {28'd0, resp_msg}, {28'd0, e});
        check_model();
        @(posedge clk); #1;
        update_model();
        resp_rdy = 1'b0;
    endtask

    logic [31:0] fn_tbl [13] = '{32'h80000004, 32'h7FFFFFFC, 32'h00000000, 32'h80000004,
                                 32'h80000004, 32'h00000001, 32'h00000000, 32'hF8000000,
                                 32'h08000000, 32'h00000000, 32'h80000004, 32'h80000000,
                                 32'h00000004};

    initial begin
        logic [31:0] ra;
        int          k;
        reset    = 1'b1;
        req_val  = 1'b0;
        req_msg  = '0;
        resp_rdy = 1'b0;
        exp_num  = 0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_req_rdy", {63'd0, req_rdy}, 64'd1);
        chk("rst_resp_val", {63'd0, resp_val}, 64'd0);
        chk("rst_num_ops", {48'd0, num_ops}, 64'd0);
        reset = 1'b0;

        // Single add
        send(4'd0, 32'd5, 32'd3);
        pop_expect("add_5_3", {4'b0000, 32'd8});
        chk("add_num_ops", {48'd0, num_ops}, 64'd1);

        // Every legal fn on 0x80000000 / 4: lt=1, ltu=0, eq=0
        for (int i = 0; i < 13; i++) begin
            send(4'(i), 32'h80000000, 32'h00000004);
            pop_expect($sformatf("fn%0d", i), {4'b0010, fn_tbl[i]});
        end

        // Backpressure: third request stalls until a slot frees
        resp_rdy = 1'b0;
        req_val  = 1'b1;
        req_msg  = {4'd0, 32'd1, 32'd1};
        cycle();
        req_msg  = {4'd0, 32'd2, 32'd2};
        cycle();
        req_msg  = {4'd0, 32'd3, 32'd3};
        cycle();
        cycle();
        #3;
        chk("bp_full_req_rdy", {63'd0, req_rdy}, 64'd0);
        pop_expect("bp_out2", {4'b0001, 32'd2});
        resp_rdy = 1'b1;
        pop_expect("bp_out4", {4'b0001, 32'd4});
        req_val = 1'b0;
        pop_expect("bp_out6", {4'b0001, 32'd6});
        chk("bp_num_ops", {48'd0, num_ops}, 64'd17);

        // Illegal fn
        send(4'd13, 32'd7, 32'd7);
        pop_expect("illegal", {4'b1001, 32'd0});

        // Streaming with resp_rdy held high
        resp_rdy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            req_val = 1'b1;
            ra      = $urandom;
            req_msg = {4'($urandom_range(0, 15)), ra, ($urandom_range(0, 3) == 0) ? ra : 32'($urandom)};
            cycle();
        end
        req_val = 1'b0;
        cycle();

        // Random valid/ready toggling
        for (int i = 0; i < 300; i++) begin
            req_val  = 1'($urandom_range(0, 1));
            resp_rdy = 1'($urandom_range(0, 1));
            ra       = $urandom;
            req_msg  = {4'($urandom_range(0, 15)), ra, ($urandom_range(0, 3) == 0) ? ra : 32'($urandom)};
            cycle();
        end
        req_val  = 1'b0;
        resp_rdy = 1'b1;
        k = 0;
        while (mq.size() != 0 && k < 10) begin
            cycle();
            k++;
        end
        chk("drain_empty", 64'(mq.size()), 64'd0);
        cycle();

        // Reset mid-operation with a full queue
        resp_rdy = 1'b0;
        send(4'd0, 32'd1, 32'd2);
        send(4'd0, 32'd3, 32'd4);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_resp_val", {63'd0, resp_val}, 64'd0);
        chk("mid_rst_req_rdy", {63'd0, req_rdy}, 64'd1);
        chk("mid_rst_num_ops", {48'd0, num_ops}, 64'd0);
        mq.delete();
        exp_num = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        send(4'd1, 32'd10, 32'd0);
        pop_expect("post_rst_sub", {4'b0000, 32'd10});
        chk("post_rst_num_ops", {48'd0, num_ops}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
